timing_decoder_unit: RTL and testbench
======================================

TIMING_DECODER_UNIT -- requirements
Module: timing_decoder_unit

Interface
REQ-001 Parameter SC_WIDTH SHALL be: default 4; width of the sequence counter; the T output width is 2**SC_WIDTH.
REQ-002 Parameter OP_WIDTH SHALL be: default 3; width of the latched opcode field; the D output width is 2**OP_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 run  input  1  SHALL, when high, request that the sequence counter increment this cycle.
REQ-006 sc_clr  input  1  SHALL, when high, request that the sequence counter clear to 0 this cycle.
REQ-007 ir_ld  input  1  SHALL, when high, request that the opcode and I bits be loaded from opcode_in.
REQ-008 opcode_in  input  OP_WIDTH+1  SHALL carry the I bit in its MSB and the opcode field in bits [OP_WIDTH-1:0].
REQ-009 sc  output  SC_WIDTH  SHALL present the current sequence counter value.
REQ-010 t  output  2**SC_WIDTH  SHALL present the one-hot timing signals: t[k]=1 if and only if sc==k.
REQ-011 d  output  2**OP_WIDTH  SHALL present the one-hot opcode decode: d[k]=1 if and only if the latched opcode==k.
REQ-012 i_bit  output  1  SHALL present the latched I (addressing-mode) bit.
REQ-013 sc_wrap  output  1  SHALL be a combinational flag that is high in any cycle where sc is at its maximum value, run=1, sc_clr=0 and rst=0.

Function
REQ-014 The sc register SHALL update at each rising clock edge using this priority: rst -> 0; else sc_clr -> 0; else run -> sc+1 modulo 2**SC_WIDTH; else hold.
REQ-015 When sc_clr and run are both high, the clear SHALL take precedence and sc SHALL become 0.
REQ-016 Wrap-around SHALL occur when sc is at its maximum (15 at default), run=1 and sc_clr=0: the next sc value is 0, and sc_wrap is high during that cycle.
REQ-017 The t output SHALL be decoded combinationally from the sc register, with zero cycles of latency from the sc register to t.
REQ-018 The t output SHALL be exactly one-hot in every cycle, including immediately after reset; t SHALL never be all-zero, multi-hot or X.
REQ-019 When ir_ld=1 and rst=0, the opcode register SHALL load opcode_in[OP_WIDTH-1:0] and the i register SHALL load opcode_in[OP_WIDTH], both at the same clock edge.
REQ-020 When ir_ld=0, the opcode and i registers SHALL hold their values.
REQ-021 The d output SHALL be decoded combinationally from the opcode register, so that d reflects a load one cycle after ir_ld is sampled.
REQ-022 The d output SHALL be exactly one-hot in every cycle and never X.
REQ-023 The ir_ld input SHALL act independently of sc_clr and run; all three may be active in the same cycle, and each SHALL take its own effect.
REQ-024 The block SHALL contain no combinational path from any input to t, d or i_bit; only sc_wrap may depend combinationally on run and sc_clr.

Reset
REQ-025 While rst=1 at a rising edge: sc SHALL become 0, the opcode register SHALL become 0, and i_bit SHALL become 0, regardless of run, sc_clr and ir_ld.
REQ-026 In the cycle after reset: t SHALL equal 0x0001, d SHALL equal 0x01, i_bit SHALL be 0, and sc_wrap SHALL be 0.
REQ-027 An rst assertion mid-count SHALL clear sc at the next edge and SHALL discard any simultaneous ir_ld.
REQ-028 The block SHALL contain no asynchronous reset paths.

Verification
REQ-029 The bench SHALL cover this scenario: apply rst, then hold run=1 for 16 cycles -> sc steps 0..15 then 0; t walks 0x0001..0x8000 then 0x0001; sc_wrap is high only in the sc=15 cycle.
REQ-030 The bench SHALL cover this scenario: run=1 until sc=5, then one cycle with sc_clr=1 and run=1 -> next sc=0 and t=0x0001.
REQ-031 The bench SHALL cover this scenario: ir_ld=1 with opcode_in=4'b1101 -> next cycle d=0x20 and i_bit=1; then ir_ld=0 with opcode_in changed -> d and i_bit hold.
REQ-032 The bench SHALL cover this scenario: run=0 and sc_clr=0 for 10 cycles at sc=3 -> sc stays 3 and t stays 0x0008.
REQ-033 The bench SHALL cover this scenario: at sc=9 with opcode latched 6, assert rst together with ir_ld=1 and opcode_in=4'b1011 -> next cycle sc=0, d=0x01, i_bit=0.
REQ-034 The bench SHALL check on every cycle that t and d are each exactly one-hot and that no output is X after the first reset.

Source files
------------

// File: rtl/timing_decoder_unit.sv
// timing_decoder_unit: sequence counter with one-hot timing decode plus latched opcode/I-bit decode
module timing_decoder_unit #(
  parameter int SC_WIDTH = 4,
  parameter int OP_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     sc_clr,
  input  logic                     ir_ld,
  input  logic [OP_WIDTH:0]        opcode_in,
  output logic [SC_WIDTH-1:0]      sc,
  output logic [2**SC_WIDTH-1:0]   t,
  output logic [2**OP_WIDTH-1:0]   d,
  output logic                     i_bit,
  output logic                     sc_wrap
);
  logic [SC_WIDTH-1:0] r_sc;
  logic [OP_WIDTH-1:0] r_op;
  logic                r_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sc <= '0;
      r_op <= '0;
      r_i  <= 1'b0;
    end else begin
      r_sc <= sc_clr ? '0 : run ? r_sc + 1'b1 : r_sc;
      if (ir_ld) begin
        r_op <= opcode_in[OP_WIDTH-1:0];
        r_i  <= opcode_in[OP_WIDTH];
      end
    end
  end
  assign sc      = r_sc;
  assign t       = {{(2**SC_WIDTH-1){1'b0}}, 1'b1} << r_sc;
  assign d       = {{(2**OP_WIDTH-1){1'b0}}, 1'b1} << r_op;
  assign i_bit   = r_i;
  assign sc_wrap = (&r_sc) & run & ~sc_clr & ~rst;
endmodule

// File: tb/tb_timing_decoder_unit.sv
// tb_timing_decoder_unit: scoreboard bench; a reference model pushes expected state each cycle, tasks pop and compare
module tb_timing_decoder_unit;
  logic        clk = 1'b0;
  logic        rst, run, sc_clr, ir_ld;
  logic [3:0]  opcode_in;
  logic [3:0]  sc;
  logic [15:0] t;
  logic [7:0]  d;
  logic        i_bit, sc_wrap;

  typedef struct {
    logic [3:0] sc;
    logic [2:0] op;
    logic       i;
    logic       wrap;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [3:0] m_sc;
  logic [2:0] m_op;
  logic       m_i;
  logic       obs_wrap;
  logic       started = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  timing_decoder_unit dut (
    .clk(clk), .rst(rst), .run(run), .sc_clr(sc_clr), .ir_ld(ir_ld),
    .opcode_in(opcode_in), .sc(sc), .t(t), .d(d), .i_bit(i_bit), .sc_wrap(sc_wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if ($countones(t) != 1 || $countones(d) != 1 || $isunknown({sc, t, d, i_bit, sc_wrap})) begin
        n_err++;
        $display("FAIL onehot_x: t=%h d=%h sc=%h i_bit=%b sc_wrap=%b, need one-hot t/d and no X", t, d, sc, i_bit, sc_wrap);
      end
    end
  end

  task automatic tick(input logic r, input logic rn, input logic clr, input logic ld, input logic [3:0] op);
    exp_t x;
    rst = r; run = rn; sc_clr = clr; ir_ld = ld; opcode_in = op;
    #2;
    obs_wrap = sc_wrap;
    x.wrap = !r && rn && !clr && (m_sc == 4'hf);
    if (r) begin
      m_sc = '0; m_op = '0; m_i = 1'b0;
    end else begin
      if (clr) m_sc = '0;
      else if (rn) m_sc = m_sc + 4'd1;
      if (ld) begin
        m_op = op[2:0];
        m_i  = op[3];
      end
    end
    x.sc = m_sc; x.op = m_op; x.i = m_i;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick(1, 1, 0, 1, 4'b1111);
    e = q.pop_front();
    started = 1'b1;
    n_cmp++;
    if (sc !== 4'd0 || t !== 16'h0001) begin
      n_err++; $display("FAIL reset_sc: sc=%h t=%h, need sc=0 t=0001", sc, t);
    end
    n_cmp++;
    if (d !== 8'h01 || i_bit !== 1'b0) begin
      n_err++; $display("FAIL reset_ir: d=%h i_bit=%b, need d=01 i_bit=0", d, i_bit);
    end
    n_cmp++;
    if (sc_wrap !== 1'b0) begin
      n_err++; $display("FAIL reset_wrap: sc_wrap=%b, need 0", sc_wrap);
    end
  endtask

  task automatic test_count;
    for (int k = 0; k < 16; k++) begin
      tick(0, 1, 0, 0, 4'b0000);
      e = q.pop_front();
      n_cmp++;
      if (sc !== e.sc || t !== (16'h0001 << e.sc)) begin
        n_err++; $display("FAIL count_step%0d: sc=%h t=%h, need sc=%h t=%h", k, sc, t, e.sc, 16'h0001 << e.sc);
      end
      n_cmp++;
      if (obs_wrap !== e.wrap) begin
        n_err++; $display("FAIL count_wrap%0d: sc_wrap=%b, need %b", k, obs_wrap, e.wrap);
      end
    end
    n_cmp++;
    if (sc !== 4'd0 || t !== 16'h0001) begin
      n_err++; $display("FAIL count_wrapped: sc=%h t=%h, need sc=0 t=0001", sc, t);
    end
  endtask

  task automatic test_clear;
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 0, 0, 4'b0000);
      e = q.pop_front();
    end
    n_cmp++;
    if (sc !== 4'd5) begin
      n_err++; $display("FAIL clear_pre: sc=%h, need 5", sc);
    end
    tick(0, 1, 1, 0, 4'b0000);
    e = q.pop_front();
    n_cmp++;
    if (sc !== 4'd0 || t !== 16'h0001) begin
      n_err++; $display("FAIL clear_prio: sc=%h t=%h, need sc=0 t=0001", sc, t);
    end
    n_cmp++;
    if (obs_wrap !== 1'b0) begin
      n_err++; $display("FAIL clear_wrap: sc_wrap=%b, need 0", obs_wrap);
    end
  endtask

  task automatic test_opcode;
    tick(0, 0, 0, 1, 4'b1101);
    e = q.pop_front();
    n_cmp++;
    if (d !== 8'h20 || i_bit !== 1'b1) begin
      n_err++; $display("FAIL op_load: d=%h i_bit=%b, need d=20 i_bit=1", d, i_bit);
    end
    tick(0, 0, 0, 0, 4'b0010);
    e = q.pop_front();
    n_cmp++;
    if (d !== 8'h20 || i_bit !== 1'b1) begin
      n_err++; $display("FAIL op_hold: d=%h i_bit=%b, need d=20 i_bit=1", d, i_bit);
    end
    tick(0, 1, 1, 1, 4'b0011);
    e = q.pop_front();
    n_cmp++;
    if (d !== 8'h08 || i_bit !== 1'b0 || sc !== 4'd0) begin
      n_err++; $display("FAIL op_concurrent: d=%h i_bit=%b sc=%h, need d=08 i_bit=0 sc=0", d, i_bit, sc);
    end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0, 4'b0000);
      e = q.pop_front();
    end
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 0, 0, 4'b0000);
      e = q.pop_front();
      n_cmp++;
      if (sc !== 4'd3 || t !== 16'h0008) begin
        n_err++; $display("FAIL hold%0d: sc=%h t=%h, need sc=3 t=0008", k, sc, t);
      end
    end
  endtask

  task automatic test_rst_mid;
    tick(0, 0, 1, 1, 4'b0110);
    e = q.pop_front();
    for (int k = 0; k < 9; k++) begin
      tick(0, 1, 0, 0, 4'b0000);
      e = q.pop_front();
    end
    n_cmp++;
    if (sc !== 4'd9 || d !== 8'h40) begin
      n_err++; $display("FAIL rstmid_pre: sc=%h d=%h, need sc=9 d=40", sc, d);
    end
    tick(1, 1, 0, 1, 4'b1011);
    e = q.pop_front();
    n_cmp++;
    if (sc !== 4'd0 || d !== 8'h01 || i_bit !== 1'b0) begin
      n_err++; $display("FAIL rstmid: sc=%h d=%h i_bit=%b, need sc=0 d=01 i_bit=0", sc, d, i_bit);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 60; k++) begin
      tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
      e = q.pop_front();
      n_cmp++;
      if (sc !== e.sc || t !== (16'h0001 << e.sc) || d !== (8'h01 << e.op) || i_bit !== e.i || obs_wrap !== e.wrap) begin
        n_err++;
        $display("FAIL rand%0d: sc=%h t=%h d=%h i=%b wrap=%b, need sc=%h t=%h d=%h i=%b wrap=%b",
                 k, sc, t, d, i_bit, obs_wrap, e.sc, 16'h0001 << e.sc, 8'h01 << e.op, e.i, e.wrap);
      end
    end
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; sc_clr = 1'b0; ir_ld = 1'b0; opcode_in = '0;
    m_sc = '0; m_op = '0; m_i = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_count;
    test_clear;
    test_opcode;
    test_hold;
    test_rst_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
